rom_readback: RTL
=================

# rom_readback

Read-side counterpart of the SD-card ROM download path: services HPS upload requests (ioctl_upload / ioctl_rd) by fetching bytes back out of the ten 4 KB ROM regions, using the same address map the download selector uses. It drives a shared 12-bit read address plus a one-hot region select toward the ROM dual-port RAMs, muxes the returned byte onto ioctl_din, and stalls the HPS with ioctl_wait until the byte is valid. It sits beside the ROM loader in the top level and is used for ROM verification and dump-back.

## Interface
Parameters:
- NUM_REGIONS, 10: number of 4 KB regions, mapped contiguously from 0x0000.
- FILL_BYTE, 8'hFF: value returned for addresses ≥ NUM_REGIONS*0x1000.

Ports:
- CLK  in  1  system clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- ioctl_upload  in  1  upload session active (level).
- ioctl_rd  in  1  one-cycle read request strobe.
- ioctl_addr  in  25  byte address of the request.
- ioctl_din  out  8  returned byte; held until next completed read.
- ioctl_wait  out  1  high while a request is in flight.
- rd_addr  out  12  shared ROM read address (ioctl_addr[11:0]).
- rd_cs  out  NUM_REGIONS  one-hot region select, bit 0 = 0x0000–0x0FFF.
- rd_data  in  8*NUM_REGIONS  read data of all regions, region k at [8k+7:8k]; one-cycle RAM latency from rd_addr.
- checksum  out  16  running byte sum of current session (see Configuration).

## Operation
- States: IDLE, ADDR, WAIT, CAPTURE.
- IDLE: on ioctl_rd=1 with ioctl_upload=1 → register ioctl_addr, raise ioctl_wait, → ADDR. ioctl_rd with ioctl_upload=0 is ignored.
- ADDR: drive rd_addr = addr[11:0], rd_cs = one-hot of addr[24:12] if < NUM_REGIONS, else all zero (out-of-range flag set). → WAIT.
- WAIT: hold rd_addr/rd_cs one cycle for RAM latency. → CAPTURE.
- CAPTURE: ioctl_din ← rd_data slice of selected region, or FILL_BYTE if out of range; drop ioctl_wait; rd_cs ← 0; update checksum. → IDLE.
- ioctl_rd while not IDLE: ignored; no queueing.
- ioctl_upload falling in any non-IDLE state: abort → IDLE next cycle, ioctl_wait=0, rd_cs=0, ioctl_din and checksum unchanged.
- Address decode is strictly by addr[24:12]; addr[11:0] wraps within a region.

## Timing
- Request accepted on edge where ioctl_rd=1 (cycle N); ioctl_wait=1 from N+1; rd_cs valid N+1..N+2; ioctl_din valid and ioctl_wait=0 at N+3. Latency 3 cycles; max throughput one byte per 3 cycles (ioctl_rd may reassert at N+3).
- Reset values: ioctl_din=0, ioctl_wait=0, rd_addr=0, rd_cs=0, checksum=0, state IDLE. RESET mid-request aborts immediately (asynchronous).
- All outputs registered; no combinational path from ioctl_* inputs to outputs.

## Configuration
- ROM_READBACK_CHECKSUM_EN defined: checksum is a 16-bit accumulator, cleared on rising edge of ioctl_upload, incremented by ioctl_din value (zero-extended, modulo 2^16) in each CAPTURE including out-of-range FILL_BYTE reads; aborted reads add nothing.
- Not defined: accumulator absent, checksum tied to 16'h0000.

## Test plan
- Reset then idle: all outputs 0; ioctl_rd with ioctl_upload=0 → ioctl_wait stays 0, rd_cs=0.
- Preload region 0 addr 0x000=0xC3; upload, rd at 0x0000 → rd_cs=10'b0000000001, rd_addr=0x000, ioctl_din=0xC3 and ioctl_wait=0 exactly 3 cycles after strobe.
- Region 9 addr 0x9FFF=0x5A → rd_cs bit 9, rd_addr=0xFFF, ioctl_din=0x5A; addr 0xA000 → rd_cs=0, ioctl_din=0xFF.
- Second ioctl_rd one cycle after first → ignored; only one completion, at first request's N+3.
- ioctl_upload dropped in WAIT → next cycle ioctl_wait=0, rd_cs=0, ioctl_din keeps prior value; RESET asserted in ADDR → all outputs 0 asynchronously.
- With ROM_READBACK_CHECKSUM_EN: read bytes 0xFF,0xFF,0x03 → checksum=0x0201; restart upload → 0x0000; without macro checksum stays 0x0000.

Source files
------------

// File: rtl/rom_readback.sv
// rom_readback: services HPS upload reads from the ten 4 KB ROM regions with a 3-cycle fetch.
// Optional running checksum enabled by defining ROM_READBACK_CHECKSUM_EN.
module rom_readback #(
  parameter int NUM_REGIONS = 10,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ioctl_upload,
  input  logic                     ioctl_rd,
  input  logic [24:0]              ioctl_addr,
  output logic [7:0]               ioctl_din,
  output logic                     ioctl_wait,
  output logic [11:0]              rd_addr,
  output logic [NUM_REGIONS-1:0]   rd_cs,
  input  logic [8*NUM_REGIONS-1:0] rd_data,
  output logic [15:0]              checksum
);
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, CAPTURE} state_t;
  state_t state, state_n;
  logic [24:0] addr_q;
  logic [12:0] page;
  logic oor, accept, abort;
  logic [NUM_REGIONS-1:0] cs_dec;
  logic [7:0] byte_sel;
  assign page = addr_q[24:12];
  assign accept = state == IDLE && ioctl_rd && ioctl_upload;
  assign abort = state != IDLE && !ioctl_upload;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? ADDR : IDLE;
      ADDR:    state_n = WAIT;
      WAIT:    state_n = CAPTURE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  always_comb begin
    cs_dec = '0;
    byte_sel = FILL_BYTE;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      cs_dec[k] = page == 13'(k);
      if (!oor && rd_cs[k]) byte_sel = rd_data[8*k +: 8];
    end
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q <= '0;
      oor <= 1'b0;
      ioctl_din <= '0;
      ioctl_wait <= 1'b0;
      rd_addr <= '0;
      rd_cs <= '0;
    end else if (abort) begin
      ioctl_wait <= 1'b0;
      rd_cs <= '0;
    end else if (accept) begin
      addr_q <= ioctl_addr;
      ioctl_wait <= 1'b1;
    end else if (state == ADDR) begin
      rd_addr <= addr_q[11:0];
      rd_cs <= cs_dec;
      oor <= page >= 13'(NUM_REGIONS);
    end else if (state == CAPTURE) begin
      ioctl_din <= byte_sel;
      ioctl_wait <= 1'b0;
      rd_cs <= '0;
    end
  end
`ifdef ROM_READBACK_CHECKSUM_EN
  logic upload_q;
  logic [15:0] sum;
  // a new upload session restarts the sum; aborted reads never reach CAPTURE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      upload_q <= 1'b0;
      sum <= '0;
    end else begin
      upload_q <= ioctl_upload;
      if (ioctl_upload && !upload_q) sum <= '0;
      else if (state == CAPTURE && !abort) sum <= sum + {8'h00, byte_sel};
    end
  end
  assign checksum = sum;
`else
  assign checksum = 16'h0000;
`endif
endmodule
